// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: boot/run sequencer between the host loader, the core and
// the single-port data memory. The host owns the memory in IDLE, LOAD and
// DONE; the core owns it in PREP and RUN. The core is held in reset while
// loading, runs for run_cycles cycles (0 = until halt), then is frozen so
// the host can read results back.
module mem_boot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic              host_start,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  output logic [15:0]       host_rdata,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              cpu_halt,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              ign_wr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PREP = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  count_r;
  logic              run_limit_s;
  logic              core_owns_s;
  logic              unused_rdata_s;

  // Only the low half of the memory word is returned to the host.
  assign unused_rdata_s = ^mem_rdata[DATA_W-1:16];

  // Bounded-run terminal count: last enabled cycle when run_cycles is nonzero.
  always_comb begin
    run_limit_s = 1'b0;
    if ((run_cycles != CNT_ZERO) && (count_r == (run_cycles - CNT_ONE))) begin
      run_limit_s = 1'b1;
    end else begin
      run_limit_s = 1'b0;
    end
  end

  // Memory port mux: core drives the port in PREP/RUN, host otherwise.
  always_comb begin
    core_owns_s = (state_r == PREP) || (state_r == RUN);
    if (core_owns_s) begin
      mem_we    = cpu_mem_we;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
    end else begin
      mem_we    = host_wr;
      mem_addr  = host_addr;
      mem_wdata = {{(DATA_W-8){1'b0}}, host_data};
    end
  end

  // Next-state decode; start has priority over a simultaneous write.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (host_start) begin
          next_state_s = PREP;
        end else if (host_wr) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (host_start) begin
          next_state_s = PREP;
        end else begin
          next_state_s = LOAD;
        end
      end
      PREP: next_state_s = RUN;
      RUN: begin
        if (cpu_halt || run_limit_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (host_start) begin
          next_state_s = PREP;
        end else if (host_wr) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus all registered outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cpu_rst    <= 1'b1;
      cpu_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ign_wr     <= 1'b0;
      host_rdata <= 16'h0000;
      count_r    <= CNT_ZERO;
    end else begin
      state_r <= next_state_s;

      case (next_state_s)
        IDLE, LOAD: begin
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        PREP: begin
          cpu_rst <= 1'b0;
          cpu_en  <= 1'b0;
          busy    <= 1'b1;
          done    <= 1'b0;
        end
        RUN: begin
          cpu_rst <= 1'b0;
          cpu_en  <= 1'b1;
          busy    <= 1'b1;
          done    <= 1'b0;
        end
        DONE: begin
          cpu_rst <= 1'b0;
          cpu_en  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          cpu_rst <= 1'b1;
          cpu_en  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase

      // Cycle counter: zeroed in PREP so the first RUN cycle sees 0; wraps freely.
      if (state_r == PREP) begin
        count_r <= CNT_ZERO;
      end else if (state_r == RUN) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end

      // Sticky dropped-write flag, cleared whenever the host (re)enters LOAD.
      if (next_state_s == LOAD) begin
        ign_wr <= 1'b0;
      end else if (host_wr && ((state_r == PREP) || (state_r == RUN))) begin
        ign_wr <= 1'b1;
      end else begin
        ign_wr <= ign_wr;
      end

      // Readback capture is honoured only in DONE.
      if ((state_r == DONE) && host_rd) begin
        host_rdata <= mem_rdata[15:0];
      end else begin
        host_rdata <= host_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Self-checking bench for mem_boot_ctrl: a small table of load-phase vectors
// followed by hand-written sequences for run, halt, readback, dropped writes
// and asynchronous reset. A behavioural memory sits on the mem_* port.
module tb_mem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_wr = 1'b0;
  logic        host_rd = 1'b0;
  logic        host_start = 1'b0;
  logic [7:0]  host_addr = 8'h00;
  logic [7:0]  host_data = 8'h00;
  logic [15:0] host_rdata;
  logic [15:0] run_cycles = 16'd0;
  logic        cpu_halt = 1'b0;
  logic        cpu_mem_we = 1'b0;
  logic [7:0]  cpu_mem_addr = 8'h00;
  logic [31:0] cpu_mem_wdata = 32'h0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_rst, cpu_en, busy, done, ign_wr;

  logic [31:0] tbmem [0:255];
  int n_vec = 0;
  int n_err = 0;

  mem_boot_ctrl #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .host_wr(host_wr), .host_rd(host_rd),
    .host_start(host_start), .host_addr(host_addr), .host_data(host_data),
    .host_rdata(host_rdata), .run_cycles(run_cycles), .cpu_halt(cpu_halt),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_rst(cpu_rst),
    .cpu_en(cpu_en), .busy(busy), .done(done), .ign_wr(ign_wr)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge.
  assign mem_rdata = tbmem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) tbmem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_cpu_rst;
    logic        e_cpu_en;
    logic        e_busy;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one RUN phase from its first cycle; returns the number of cycles
  // cpu_en was seen high. inject adds a core write and two host writes.
  task automatic run_loop(input int halt_at, input bit inject, output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      cpu_halt      = (n == halt_at);
      host_wr       = inject && (n < 2);
      host_addr     = 8'h55;
      host_data     = 8'hAA;
      cpu_mem_we    = inject && (n == 0);
      cpu_mem_addr  = 8'h08;
      cpu_mem_wdata = 32'h0001_0019;
      #1;
      if (!cpu_en) break;
      chk("run.busy", 32'(busy), 32'd1);
      chk("run.cpu_rst", 32'(cpu_rst), 32'd0);
      if (inject && n == 0) begin
        chk("run.core_we", 32'(mem_we), 32'd1);
        chk("run.core_addr", 32'(mem_addr), 32'h08);
        chk("run.core_wdata", mem_wdata, 32'h0001_0019);
      end
      if (inject && n == 1) begin
        chk("run.host_wr_dropped", 32'(mem_we), 32'd0);
        chk("run.ign_wr", 32'(ign_wr), 32'd1);
      end
      n++;
      @(negedge clk);
    end
    cpu_halt = 1'b0; host_wr = 1'b0; cpu_mem_we = 1'b0;
    host_addr = 8'h00; host_data = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int a = 0; a < 256; a++) tbmem[a] = 32'h0;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h03, 1'b1, 8'h00, 32'd3, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[1] = '{1'b1, 1'b0, 8'h04, 8'h05, 1'b1, 8'h04, 32'd5, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[2] = '{1'b1, 1'b0, 8'h08, 8'h00, 1'b1, 8'h08, 32'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[3] = '{1'b1, 1'b0, 8'h10, 8'h07, 1'b1, 8'h10, 32'd7, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[4] = '{1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 8'h04, 32'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 1'b0, 16'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst.cpu_en", 32'(cpu_en), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ign_wr", 32'(ign_wr), 32'd0);
    chk("rst.host_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b0;

    // Load phase from the table (includes a read in LOAD that must be ignored).
    for (int i = 0; i < 6; i++) begin
      host_wr = tbl[i].wr; host_rd = tbl[i].rd;
      host_addr = tbl[i].addr; host_data = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("tbl%0d.cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].e_cpu_rst));
      chk($sformatf("tbl%0d.cpu_en", i), 32'(cpu_en), 32'(tbl[i].e_cpu_en));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.host_rdata", i), 32'(host_rdata), 32'(tbl[i].e_rdata));
      @(negedge clk);
    end
    host_rd = 1'b0;
    chk("load.mem0", tbmem[0], 32'd3);
    chk("load.mem4", tbmem[4], 32'd5);
    chk("load.mem16", tbmem[16], 32'd7);

    // Bounded run of 10 cycles with a core write and dropped host writes.
    run_cycles = 16'd10;
    host_start = 1'b1;
    #1 chk("start.cpu_rst", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    host_start = 1'b0;
    #1;
    chk("prep.busy", 32'(busy), 32'd1);
    chk("prep.cpu_rst", 32'(cpu_rst), 32'd0);
    chk("prep.cpu_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    run_loop(-1, 1'b1, n);
    chk("bounded.cycles", 32'(n), 32'd10);
    chk("bounded.done", 32'(done), 32'd1);
    chk("bounded.busy", 32'(busy), 32'd0);
    chk("bounded.cpu_rst", 32'(cpu_rst), 32'd0);
    chk("bounded.ign_wr", 32'(ign_wr), 32'd1);
    chk("bounded.mem8", tbmem[8], 32'h0001_0019);
    chk("bounded.mem55", tbmem[8'h55], 32'h0);

    // Readback of address 8, then hold after host_rd drops.
    @(negedge clk);
    host_rd = 1'b1; host_addr = 8'h08;
    #1 chk("rb.mem_addr", 32'(mem_addr), 32'h08);
    @(negedge clk);
    host_rd = 1'b0; host_addr = 8'h00;
    #1 chk("rb.rdata", 32'(host_rdata), 32'h0019);
    @(negedge clk);
    #1 chk("rb.hold", 32'(host_rdata), 32'h0019);

    // Unlimited run terminated by halt on the 37th RUN cycle.
    run_cycles = 16'd0;
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    #1 chk("prep2.busy", 32'(busy), 32'd1);
    @(negedge clk);
    run_loop(36, 1'b0, n);
    chk("halt.cycles", 32'(n), 32'd37);
    chk("halt.done", 32'(done), 32'd1);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    #1;
    chk("halt2.done", 32'(done), 32'd1);
    chk("halt2.cpu_en", 32'(cpu_en), 32'd0);
    chk("halt2.busy", 32'(busy), 32'd0);
    chk("halt2.ign_wr", 32'(ign_wr), 32'd1);

    // Host write in DONE goes back to LOAD, commits and clears ign_wr.
    host_wr = 1'b1; host_addr = 8'h20; host_data = 8'h09;
    #1;
    chk("doneWr.mem_we", 32'(mem_we), 32'd1);
    chk("doneWr.mem_wdata", mem_wdata, 32'h09);
    @(negedge clk);
    host_wr = 1'b0;
    #1;
    chk("doneWr.ign_wr", 32'(ign_wr), 32'd0);
    chk("doneWr.cpu_rst", 32'(cpu_rst), 32'd1);
    chk("doneWr.done", 32'(done), 32'd0);
    chk("doneWr.mem32", tbmem[32], 32'h09);

    // Start with a simultaneous write, then async reset mid-RUN.
    @(negedge clk);
    host_wr = 1'b1; host_start = 1'b1; host_addr = 8'h28; host_data = 8'h11;
    #1 chk("startWr.mem_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    host_wr = 1'b0; host_start = 1'b0;
    #1;
    chk("startWr.busy", 32'(busy), 32'd1);
    chk("startWr.mem40", tbmem[40], 32'h11);
    @(negedge clk);
    #1 chk("run3.cpu_en", 32'(cpu_en), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.cpu_en", 32'(cpu_en), 32'd0);
    chk("arst.cpu_rst", 32'(cpu_rst), 32'd1);
    chk("arst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst.done", 32'(done), 32'd0);

    // Re-run from IDLE with the minimum bounded length.
    run_cycles = 16'd1;
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    #1 chk("prep4.busy", 32'(busy), 32'd1);
    @(negedge clk);
    run_loop(-1, 1'b0, n);
    chk("one.cycles", 32'(n), 32'd1);
    chk("one.done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
